// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 memory arbiter slice.
package mic1_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned WAIT_W = 8;

  localparam logic [IDX_W-1:0] REQ_FETCH  = IDX_W'(0);
  localparam logic [IDX_W-1:0] REQ_DATA   = IDX_W'(1);
  localparam logic [IDX_W-1:0] REQ_LOADER = IDX_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Next requester index, wrapping after the last one.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/mic1_rr_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr, circularly.
module mic1_rr_pick
  import mic1_pkg::*;
(
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    index  = '0;
    any    = 1'b0;
    w_cand = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any && eligible[w_cand]) begin
        index = w_cand;
        any   = 1'b1;
      end
      w_cand = idx_inc(w_cand);
    end
  end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// Three-requester arbiter (fetch, data, UART loader) onto one memory port,
// one transaction at a time, round-robin with a boot-mode loader-only mask.
module mic1_mem_arbiter
  import mic1_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             boot_mode,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]      req_wdata,
  input  logic [NREQ-1:0][DATA_W/8-1:0]    req_wstrb,
  output logic [NREQ-1:0]                  req_ready,
  output logic [DATA_W-1:0]                req_rdata,
  output logic                             req_err,
  output logic                             mem_valid,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  output logic [DATA_W/8-1:0]              mem_wstrb,
  input  logic                             mem_ready,
  input  logic [DATA_W-1:0]                mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [NREQ-1:0] BOOT_MASK = NREQ'(1) << REQ_LOADER;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic [NREQ-1:0]     r_req_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_rr_ptr_nxt;
  logic [IDX_W-1:0]    w_grant_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                w_mem_valid_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic [STRB_W-1:0]   w_mem_wstrb_nxt;
  logic [NREQ-1:0]     w_req_ready_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_err_nxt;

  logic [NREQ-1:0]     w_eligible;
  logic [IDX_W-1:0]    w_pick;
  logic                w_any;

  assign w_eligible = req_valid & (boot_mode ? BOOT_MASK : {NREQ{1'b1}});

  mic1_rr_pick u_pick (
    .eligible (w_eligible),
    .ptr      (r_rr_ptr),
    .index    (w_pick),
    .any      (w_any)
  );

  // Next-state and next-output logic; memory request is launched on the grant edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_nxt     = r_grant;
    w_wait_nxt      = r_wait;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_req_ready_nxt = '0;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt     = BUSY;
          w_grant_nxt     = w_pick;
          w_wait_nxt      = '0;
          w_mem_valid_nxt = 1'b1;
          w_mem_addr_nxt  = req_addr[w_pick];
          w_mem_wdata_nxt = req_wdata[w_pick];
          w_mem_wstrb_nxt = req_wstrb[w_pick];
        end
      end
      BUSY: begin
        if (mem_ready) begin
          w_state_nxt     = DONE;
          w_mem_valid_nxt = 1'b0;
          w_rdata_nxt     = mem_rdata;
          w_err_nxt       = 1'b0;
          w_req_ready_nxt = NREQ'(1) << r_grant;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt     = DONE;
          w_mem_valid_nxt = 1'b0;
          w_rdata_nxt     = '0;
          w_err_nxt       = 1'b1;
          w_req_ready_nxt = NREQ'(1) << r_grant;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = idx_inc(r_grant);
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_wait      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_req_ready <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_wait      <= w_wait_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign req_ready = r_req_ready;
  assign req_rdata = r_rdata;
  assign req_err   = r_err;

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed scoreboard bench for mic1_mem_arbiter with a behavioural memory responder.
module tb_mic1_mem_arbiter;

  logic              clk;
  logic              reset;
  logic              boot_mode;
  logic [2:0]        req_valid;
  logic [2:0][31:0]  req_addr;
  logic [2:0][31:0]  req_wdata;
  logic [2:0][3:0]   req_wstrb;
  logic [2:0]        req_ready;
  logic [31:0]       req_rdata;
  logic              req_err;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  logic model_ready;
  logic mem_force;
  assign mem_ready = model_ready | mem_force;

  mic1_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .boot_mode (boot_mode),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .req_err   (req_err),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   issues[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mem_wait = 0;
  bit   mem_stall = 1'b0;
  int   mem_cnt = 0;
  int   run_len = 0;
  int   last_len = 0;
  int   resp_cyc = 0;
  bit   prev_valid = 1'b0;
  bit   auto_drop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input bit err);
    exp_t e;
    e.idx   = 2'(i);
    e.addr  = req_addr[i];
    e.wdata = req_wdata[i];
    e.wstrb = req_wstrb[i];
    e.err   = err;
    e.rdata = (err || req_wstrb[i] != 4'h0) ? 32'h0 : exp_data(req_addr[i]);
    sb_q.push_back(e);
  endtask

  // Wait for n completion pulses; optionally release each served requester.
  task automatic wait_ready(input int n, input int budget);
    int seen = 0;
    int b = 0;
    while (seen < n && b < budget) begin
      @(negedge clk);
      b++;
      if (|req_ready) begin
        seen++;
        if (auto_drop) req_valid = req_valid & ~req_ready;
      end
    end
    chk("wait_ready_count", 64'(seen), 64'(n));
  endtask

  // Memory responder plus completion scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      model_ready = 1'b0;
      mem_cnt     = 0;
      prev_valid  = 1'b0;
    end else begin
      model_ready = 1'b0;
      mem_rdata   = $urandom();
      if (mem_valid) begin
        if (!prev_valid) begin
          issues.push_back(cyc);
          run_len = 0;
        end
        run_len++;
        if (sb_q.size() == 0) begin
          chk("mem_unexpected", 64'(mem_valid), 64'(0));
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(sb_q[0].addr));
          if (!mem_stall && mem_cnt == mem_wait) begin
            chk("mem_wdata", 64'(mem_wdata), 64'(sb_q[0].wdata));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(sb_q[0].wstrb));
            model_ready = 1'b1;
            mem_rdata   = (mem_wstrb == 4'h0) ? exp_data(mem_addr) : 32'h0;
            resp_cyc    = cyc;
          end
        end
        mem_cnt++;
      end else begin
        if (prev_valid) last_len = run_len;
        mem_cnt = 0;
      end
      prev_valid = mem_valid;
      if (|req_ready) begin
        if (sb_q.size() == 0) begin
          chk("ready_unexpected", 64'(req_ready), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ready_onehot", 64'(req_ready), 64'(3'b001 << e.idx));
          chk("ready_rdata", 64'(req_rdata), 64'(e.rdata));
          chk("ready_err", 64'(req_err), 64'(e.err));
          if (!e.err) chk("ready_latency", 64'(cyc), 64'(resp_cyc + 1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b;
    reset     = 1'b1;
    boot_mode = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    mem_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_req_rdata", 64'(req_rdata), 64'(0));
    chk("rst_req_err", 64'(req_err), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));

    // Contention: all three held valid out of reset, zero-wait memory.
    req_addr[0] = 32'h1000;
    req_addr[1] = 32'h2004;
    req_addr[2] = 32'h3008;
    req_wdata[1] = 32'hCAFE0001;
    mem_wait = 0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) push(i, 1'b0);
    n = issues.size();
    req_valid = 3'b111;
    @(negedge clk);
    reset = 1'b0;
    auto_drop = 1'b0;
    wait_ready(6, 60);
    req_valid = '0;
    chk("cont_issue_count", 64'(issues.size() - n), 64'(6));
    for (int k = 1; k < 6; k++) chk("cont_issue_gap", 64'(issues[n+k] - issues[n+k-1]), 64'(3));

    // Single read with two wait cycles.
    auto_drop = 1'b1;
    req_addr[0] = 32'h100;
    mem_wait = 2;
    push(0, 1'b0);
    req_valid = 3'b001;
    wait_ready(1, 30);
    @(negedge clk);
    chk("read_valid_len", 64'(last_len), 64'(3));

    // Timeout: memory never answers.
    req_addr[1] = 32'h204;
    mem_stall = 1'b1;
    push(1, 1'b1);
    req_valid = 3'b010;
    wait_ready(1, 30);
    @(negedge clk);
    chk("timeout_valid_len", 64'(last_len), 64'(8));
    mem_stall = 1'b0;
    mem_wait = 1;

    // Boot mode: only the loader may be granted.
    boot_mode = 1'b1;
    req_addr[0] = 32'h10;
    req_addr[1] = 32'h14;
    n = issues.size();
    req_valid = 3'b011;
    repeat (20) @(negedge clk);
    chk("boot_blocked", 64'(issues.size()), 64'(n));
    req_addr[2]  = 32'h40;
    req_wdata[2] = 32'h12345678;
    req_wstrb[2] = 4'hF;
    push(2, 1'b0);
    req_valid[2] = 1'b1;
    wait_ready(1, 30);
    repeat (6) @(negedge clk);
    chk("boot_only_loader", 64'(issues.size()), 64'(n + 1));
    push(0, 1'b0);
    push(1, 1'b0);
    boot_mode = 1'b0;
    wait_ready(2, 40);

    // Stray mem_ready while idle must do nothing.
    n = issues.size();
    mem_force = 1'b1;
    @(negedge clk);
    mem_force = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ready_idle", 64'(issues.size()), 64'(n));

    // A requester that withdraws before any IDLE decision is never served.
    req_addr[0] = 32'h500;
    mem_wait = 4;
    push(0, 1'b0);
    req_valid = 3'b001;
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b0;
    wait_ready(1, 30);
    repeat (5) @(negedge clk);
    chk("drop_not_served", 64'(issues.size()), 64'(n + 1));

    // Reset while BUSY: abandon, then first grant restarts from requester 0.
    req_addr[1] = 32'h600;
    mem_stall = 1'b1;
    push(1, 1'b0);
    req_valid = 3'b010;
    b = 0;
    while (!mem_valid && b < 10) begin
      @(negedge clk);
      b++;
    end
    chk("rst_busy_entered", 64'(mem_valid), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 64'(mem_valid), 64'(0));
    chk("rst_async_ready", 64'(req_ready), 64'(0));
    sb_q.delete();
    mem_stall = 1'b0;
    mem_wait = 0;
    req_addr[0] = 32'h700;
    req_addr[2] = 32'h708;
    req_wstrb[2] = 4'h0;
    req_valid = 3'b111;
    push(0, 1'b0);
    push(1, 1'b0);
    push(2, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready(3, 40);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic1_mem_arbiter.md
MIC1_MEM_ARBITER -- requirements
Module: mic1_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width; wstrb width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255, maximum wait in cycles for mem_ready before an error completion; legal range 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and reset are listed first.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 boot_mode  input  1  when high, only requester 2 (UART loader) is eligible for a grant.
REQ-008 req_valid  input  [2:0]  per-requester request; 0 = MIC-1 fetch, 1 = MIC-1 data, 2 = UART loader.
REQ-009 req_addr  input  [2:0][ADDR_W-1:0]  per-requester byte address.
REQ-010 req_wdata  input  [2:0][DATA_W-1:0]  per-requester write data.
REQ-011 req_wstrb  input  [2:0][DATA_W/8-1:0]  per-requester byte enables; all zero means read.
REQ-012 req_ready  output  [2:0]  one-cycle completion pulse to the granted requester.
REQ-013 req_rdata  output  [DATA_W-1:0]  read data, shared and valid only while some req_ready bit is high.
REQ-014 req_err  output  1  completion was a timeout; valid only while some req_ready bit is high.
REQ-015 mem_valid, mem_addr, mem_wdata, mem_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  single shared memory port request.
REQ-016 mem_ready  input  1  memory completion; mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  input  [DATA_W-1:0]  memory read data.

Function
REQ-018 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-019 In IDLE, eligible = req_valid masked by boot_mode (mask 3'b100 when boot_mode is high, else 3'b111); if eligible is nonzero, grant the first eligible index scanning upward circularly from rr_ptr, latch its addr/wdata/wstrb and index, and go to BUSY.
REQ-020 In BUSY, mem_valid SHALL be 1 and mem_addr/wdata/wstrb SHALL be the latched values, constant for the whole state.
REQ-021 In BUSY, when mem_ready is 1: register mem_rdata, set err to 0, go to DONE.
REQ-022 BUSY SHALL count wait cycles; when the count reaches TIMEOUT with mem_ready still 0: drop mem_valid, set rdata to 0 and err to 1, go to DONE.
REQ-023 In DONE, exactly req_ready[grant] SHALL be 1, with req_rdata and req_err driven from the registered values; next state is IDLE; rr_ptr <= (grant+1) mod 3.
REQ-024 Latency: request sampled in IDLE at cycle N, mem_valid from N+1, mem_ready at cycle M, req_ready at M+1; minimum issue-to-issue spacing is 3 cycles.
REQ-025 Requesters SHALL hold their valid and payload until req_ready; the arbiter ignores payload changes after the latch.
REQ-026 A boot_mode change takes effect only at the next IDLE decision; an in-flight transaction completes normally.
REQ-027 A mem_ready that arrives while not in BUSY SHALL be ignored.
REQ-028 A requester that drops valid before its grant is not served, and no state changes as a result.

Reset
REQ-029 Reset SHALL force state=IDLE, rr_ptr=0, wait count=0, mem_valid=0, mem_addr/wdata/wstrb=0, req_ready=0, req_rdata=0, req_err=0.
REQ-030 Reset mid-transaction SHALL abandon it with no req_ready pulse; the first post-reset grant uses rr_ptr=0.

Structure
REQ-031 The state enum, requester index constants (REQ_FETCH=0, REQ_DATA=1, REQ_LOADER=2) and NREQ=3 SHALL live in the shared package mic1_pkg.
REQ-032 The round-robin pick SHALL be a sub-module mic1_rr_pick (inputs eligible and ptr; outputs index and any), which is purely combinational.

Verification
REQ-033 Single read: req_valid=3'b001, addr 0x100, memory returns 0xDEADBEEF after 2 wait cycles -> mem_valid for 3 cycles, req_ready=3'b001 one cycle later, rdata=0xDEADBEEF, err=0.
REQ-034 Contention: all three valid continuously from reset, zero-wait memory -> grant order 0,1,2,0,1,2 with issue spacing of 3 cycles.
REQ-035 Boot mode: boot_mode=1, req_valid=3'b011 -> no mem_valid for 20 cycles; req 2 then asserts a write of 0x12345678, wstrb 4'hF -> only requester 2 is served.
REQ-036 Timeout: TIMEOUT=8, mem_ready held at 0 -> mem_valid drops after 8 cycles, req_ready pulses with err=1 and rdata=0.
REQ-037 Reset in BUSY: assert reset while mem_valid=1 -> mem_valid=0 immediately (asynchronous), no req_ready pulse, next grant follows rr_ptr=0.
